// File: rtl/ltsm_sb_pkg.sv
// Sideband message codes shared by the LTSM substate blocks, plus the state
// encoding used by the single-exchange handshake responders.
package ltsm_sb_pkg;

    localparam logic [3:0] SB_MSG_NONE              = 4'd0;
    localparam logic [3:0] SB_TRAINERROR_ENTRY_REQ  = 4'd15;
    localparam logic [3:0] SB_TRAINERROR_ENTRY_RESP = 4'd14;

    typedef enum logic [2:0] {
        HS_IDLE,
        HS_WAIT_REQ,
        HS_DEFER,
        HS_SEND_RESP,
        HS_DONE,
        HS_TIMEOUT
    } hs_state_e;

    // The sideband transmitter is usable only when it is idle and the local TX
    // handshake is not holding it.
    function automatic logic sb_bus_free(input logic sb_busy, input logic tx_valid);
        return !sb_busy && !tx_valid;
    endfunction

endpackage

// File: rtl/ltsm_hs_timeout_cnt.sv
// Saturating progress counter for sideband handshakes: raises o_tc while the
// count sits at LIMIT-1. LIMIT of 0 disables the terminal flag.
module ltsm_hs_timeout_cnt #(
    parameter int W     = 20,
    parameter int LIMIT = 800000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [W-1:0] TERM = (LIMIT == 0) ? {W{1'b1}} : W'(LIMIT - 1);

    logic [W-1:0] cnt;

    // Clear dominates enable; the count parks at TERM instead of wrapping.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            cnt <= '0;
        end else if (i_en && (cnt != TERM)) begin
            cnt <= cnt + W'(1);
        end
    end

    assign o_tc = (LIMIT != 0) && (cnt == TERM);

endmodule

// File: rtl/ltsm_rx_hs_responder.sv
// RX-side sideband responder: answers the partner's REQ_MSG with RESP_MSG,
// yielding the bus to local TX, counting exchanges and watching for a stall.
module ltsm_rx_hs_responder
    import ltsm_sb_pkg::*;
#(
    parameter int                      SB_MSG_WIDTH   = 4,
    parameter logic [SB_MSG_WIDTH-1:0] REQ_MSG        = SB_MSG_WIDTH'(SB_TRAINERROR_ENTRY_REQ),
    parameter logic [SB_MSG_WIDTH-1:0] RESP_MSG       = SB_MSG_WIDTH'(SB_TRAINERROR_ENTRY_RESP),
    parameter int                      N_HS           = 1,
    parameter int                      CNT_W          = 4,
    parameter int                      TIMEOUT_CYCLES = 800000,
    parameter int                      TO_W           = 20
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic                    i_sb_msg_valid,
    input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
    input  logic                    i_sb_busy,
    input  logic                    i_sb_busy_fall,
    input  logic                    i_tx_valid,
    output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg,
    output logic                    o_valid,
    output logic                    o_done,
    output logic                    o_timeout,
    output logic [CNT_W-1:0]        o_hs_count
);

    localparam logic [CNT_W-1:0] N_HS_C = CNT_W'(N_HS);

    hs_state_e                 state, state_next;
    logic                      retry, retry_next;
    logic                      valid_next, done_next, timeout_next;
    logic [SB_MSG_WIDTH-1:0]   msg_next;
    logic [CNT_W-1:0]          count_next;
    logic                      accept, bus_free, counting, expire;
    logic                      to_clr, to_en, to_tc;

    assign accept   = i_sb_msg_valid && (i_decoded_SB_msg == REQ_MSG);
    assign bus_free = sb_bus_free(i_sb_busy, i_tx_valid);
    assign counting = state inside {HS_WAIT_REQ, HS_DEFER, HS_SEND_RESP};
    // A fresh request at the terminal count still counts as progress.
    assign expire   = to_tc && counting && !(accept && (state == HS_WAIT_REQ));

    ltsm_hs_timeout_cnt #(
        .W     (TO_W),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (to_clr),
        .i_en  (to_en),
        .o_tc  (to_tc)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state            <= HS_IDLE;
            retry            <= 1'b0;
            o_valid          <= 1'b0;
            o_encoded_SB_msg <= '0;
            o_done           <= 1'b0;
            o_timeout        <= 1'b0;
            o_hs_count       <= '0;
        end else begin
            state            <= state_next;
            retry            <= retry_next;
            o_valid          <= valid_next;
            o_encoded_SB_msg <= msg_next;
            o_done           <= done_next;
            o_timeout        <= timeout_next;
            o_hs_count       <= count_next;
        end
    end

    // In SEND_RESP, a low o_valid means the message has left the bus and the
    // exchange is being retired; retry marks a re-answer issued from DONE.
    always_comb begin
        state_next   = state;
        retry_next   = retry;
        valid_next   = o_valid;
        msg_next     = o_encoded_SB_msg;
        done_next    = o_done;
        timeout_next = o_timeout;
        count_next   = o_hs_count;
        to_clr       = 1'b0;
        to_en        = counting;

        if (!i_en) begin
            state_next   = HS_IDLE;
            retry_next   = 1'b0;
            valid_next   = 1'b0;
            msg_next     = '0;
            done_next    = 1'b0;
            timeout_next = 1'b0;
            count_next   = '0;
            to_clr       = 1'b1;
        end else if (expire) begin
            state_next   = HS_TIMEOUT;
            timeout_next = 1'b1;
            valid_next   = 1'b0;
            msg_next     = '0;
        end else begin
            case (state)
                HS_IDLE: begin
                    to_clr     = 1'b1;
                    state_next = HS_WAIT_REQ;
                end
                HS_WAIT_REQ, HS_DONE: begin
                    if (accept) begin
                        to_clr     = 1'b1;
                        retry_next = (state == HS_DONE);
                        msg_next   = RESP_MSG;
                        if (bus_free) begin
                            state_next = HS_SEND_RESP;
                            valid_next = 1'b1;
                        end else begin
                            state_next = HS_DEFER;
                        end
                    end
                end
                HS_DEFER: begin
                    if (bus_free) begin
                        state_next = HS_SEND_RESP;
                        valid_next = 1'b1;
                    end
                end
                HS_SEND_RESP: begin
                    if (o_valid) begin
                        if (i_sb_busy_fall) begin
                            valid_next = 1'b0;
                            msg_next   = '0;
                        end
                    end else if (retry) begin
                        state_next = HS_DONE;
                        retry_next = 1'b0;
                        to_clr     = 1'b1;
                    end else begin
                        count_next = (o_hs_count == N_HS_C) ? o_hs_count : o_hs_count + CNT_W'(1);
                        if (count_next == N_HS_C) begin
                            state_next = HS_DONE;
                            done_next  = 1'b1;
                            to_clr     = 1'b1;
                        end else begin
                            state_next = HS_WAIT_REQ;
                        end
                    end
                end
                HS_TIMEOUT: begin
                end
                default: state_next = HS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ltsm_rx_hs_responder.sv
// Bench for ltsm_rx_hs_responder: three differently parameterised instances share
// one stimulus stream and are compared each cycle to a transaction-level model.
module tb_ltsm_rx_hs_responder;

    localparam int NDUT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       sb_msg_valid = 1'b0;
    logic [3:0] decoded_msg = 4'd0;
    logic       sb_busy = 1'b0;
    logic       sb_busy_fall = 1'b0;
    logic       tx_valid = 1'b0;

    logic       d_valid   [NDUT];
    logic [3:0] d_msg     [NDUT];
    logic       d_done    [NDUT];
    logic       d_timeout [NDUT];
    logic [3:0] d_count   [NDUT];

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  check_on = 1'b0;

    always #5 clk = ~clk;

    ltsm_rx_hs_responder #(.N_HS(1)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_sb_msg_valid(sb_msg_valid),
        .i_decoded_SB_msg(decoded_msg), .i_sb_busy(sb_busy), .i_sb_busy_fall(sb_busy_fall),
        .i_tx_valid(tx_valid), .o_encoded_SB_msg(d_msg[0]), .o_valid(d_valid[0]),
        .o_done(d_done[0]), .o_timeout(d_timeout[0]), .o_hs_count(d_count[0])
    );

    ltsm_rx_hs_responder #(.N_HS(3), .TIMEOUT_CYCLES(0), .TO_W(4)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_sb_msg_valid(sb_msg_valid),
        .i_decoded_SB_msg(decoded_msg), .i_sb_busy(sb_busy), .i_sb_busy_fall(sb_busy_fall),
        .i_tx_valid(tx_valid), .o_encoded_SB_msg(d_msg[1]), .o_valid(d_valid[1]),
        .o_done(d_done[1]), .o_timeout(d_timeout[1]), .o_hs_count(d_count[1])
    );

    ltsm_rx_hs_responder #(.N_HS(2), .TIMEOUT_CYCLES(50), .TO_W(6)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_sb_msg_valid(sb_msg_valid),
        .i_decoded_SB_msg(decoded_msg), .i_sb_busy(sb_busy), .i_sb_busy_fall(sb_busy_fall),
        .i_tx_valid(tx_valid), .o_encoded_SB_msg(d_msg[2]), .o_valid(d_valid[2]),
        .o_done(d_done[2]), .o_timeout(d_timeout[2]), .o_hs_count(d_count[2])
    );

    function automatic int dut_n_hs(input int k);
        case (k)
            0: return 1;
            1: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int dut_to(input int k);
        case (k)
            0: return 800000;
            1: return 0;
            default: return 50;
        endcase
    endfunction

    // Reference model: an exchange moves through "owed" (bus not yet free),
    // "sending" (message on the bus) and "wrapup" (retire the exchange).
    typedef struct {
        bit active;
        bit owed;
        bit sending;
        bit wrapup;
        bit retrying;
        bit timed_out;
        bit done;
        bit valid;
        int msg;
        int completed;
        int quiet;
    } model_t;

    model_t models [NDUT];

    function automatic model_t model_reset();
        model_t m;
        m.active = 0; m.owed = 0; m.sending = 0; m.wrapup = 0; m.retrying = 0;
        m.timed_out = 0; m.done = 0; m.valid = 0; m.msg = 0; m.completed = 0; m.quiet = 0;
        return m;
    endfunction

    function automatic model_t model_next(input model_t m, input int n_hs, input int to_cycles);
        model_t n;
        bit acc, bus_ok, in_flight, parked, expire, takes;
        n         = m;
        acc       = sb_msg_valid && (decoded_msg == 4'd15);
        bus_ok    = !sb_busy && !tx_valid;
        in_flight = m.owed || m.sending || m.wrapup;
        parked    = m.done && !in_flight;
        expire    = (to_cycles != 0) && !parked && (m.quiet == to_cycles - 1);
        takes     = acc && !in_flight;
        if (rst || !en) return model_reset();
        if (!m.active) begin
            n.active = 1;
            n.quiet  = 0;
            return n;
        end
        if (m.timed_out) return n;
        if (!parked) n.quiet = m.quiet + 1;
        if (takes) begin
            n.quiet    = 0;
            n.msg      = 14;
            n.retrying = m.done;
            if (bus_ok) begin
                n.sending = 1;
                n.valid   = 1;
            end else begin
                n.owed = 1;
            end
        end else if (expire) begin
            n.timed_out = 1;
            n.valid = 0; n.msg = 0; n.owed = 0; n.sending = 0; n.wrapup = 0;
        end else if (m.owed) begin
            if (bus_ok) begin
                n.owed = 0; n.sending = 1; n.valid = 1;
            end
        end else if (m.sending) begin
            if (sb_busy_fall) begin
                n.sending = 0; n.wrapup = 1; n.valid = 0; n.msg = 0;
            end
        end else if (m.wrapup) begin
            n.wrapup = 0;
            if (!m.retrying) n.completed = (m.completed + 1 > n_hs) ? n_hs : m.completed + 1;
            if (m.retrying || n.completed == n_hs) begin
                n.done = 1; n.quiet = 0; n.retrying = 0;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < NDUT; k++) models[k] = model_next(models[k], dut_n_hs(k), dut_to(k));
    end

    function automatic logic [10:0] exp_out(input bit v, input int m, input bit d, input bit t, input int c);
        return {v, 4'(m), d, t, 4'(c)};
    endfunction

    function automatic logic [10:0] dut_pack(input int k);
        return {d_valid[k], d_msg[k], d_done[k], d_timeout[k], d_count[k]};
    endfunction

    function automatic logic [10:0] model_pack(input int k);
        return exp_out(models[k].valid, models[k].msg, models[k].done, models[k].timed_out, models[k].completed);
    endfunction

    task automatic checkOutput(input string name, input logic [10:0] act, input logic [10:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL %s @%0t: got valid=%b msg=%0d done=%b timeout=%b count=%0d, expected valid=%b msg=%0d done=%b timeout=%b count=%0d",
                     name, $time, act[10], act[9:6], act[5], act[4], act[3:0],
                     exp_v[10], exp_v[9:6], exp_v[5], exp_v[4], exp_v[3:0]);
        end
    endtask

    always @(negedge clk) begin
        if (check_on) begin
            for (int k = 0; k < NDUT; k++) checkOutput($sformatf("model_dut%0d", k), dut_pack(k), model_pack(k));
        end
    end

    task automatic applyStimulus(input logic a_en, input logic a_mv, input logic [3:0] a_msg,
                                 input logic a_busy, input logic a_fall, input logic a_tx);
        en           = a_en;
        sb_msg_valid = a_mv;
        decoded_msg  = a_msg;
        sb_busy      = a_busy;
        sb_busy_fall = a_fall;
        tx_valid     = a_tx;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    typedef struct {
        logic       en, mv;
        logic [3:0] msg;
        logic       busy, fall, tx;
        logic       v;
        logic [3:0] m;
        logic       d;
        int         c;
    } vec_t;

    vec_t vecs [13];

    initial begin
        logic [3:0] rmsg;

        vecs[0]  = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 0};
        vecs[1]  = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 0};
        vecs[2]  = '{1'b1, 1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1, 4'd14, 1'b0, 0};
        vecs[3]  = '{1'b1, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 4'd14, 1'b0, 0};
        vecs[4]  = '{1'b1, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 4'd14, 1'b0, 0};
        vecs[5]  = '{1'b1, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 4'd14, 1'b0, 0};
        vecs[6]  = '{1'b1, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 4'd14, 1'b0, 0};
        vecs[7]  = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 0};
        vecs[8]  = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1};
        vecs[9]  = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1};
        vecs[10] = '{1'b1, 1'b1, 4'd13, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1};
        vecs[11] = '{1'b1, 1'b0, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1};
        vecs[12] = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 0};

        rst = 1'b1;
        applyStimulus(0, 0, 4'd0, 0, 0, 0);
        step();
        step();
        for (int k = 0; k < NDUT; k++) checkOutput($sformatf("reset_dut%0d", k), dut_pack(k), exp_out(0, 0, 0, 0, 0));
        rst = 1'b0;
        step();
        check_on = 1'b1;

        // Single exchange on an idle bus, then noise while parked in DONE.
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].en, vecs[i].mv, vecs[i].msg, vecs[i].busy, vecs[i].fall, vecs[i].tx);
            step();
            checkOutput($sformatf("vec%0d", i), dut_pack(0), exp_out(vecs[i].v, vecs[i].m, vecs[i].d, 0, vecs[i].c));
        end

        // Local TX holds the bus for ten cycles after the request arrives.
        applyStimulus(1, 0, 4'd0, 0, 0, 0);
        step();
        applyStimulus(1, 1, 4'd15, 0, 0, 1);
        step();
        checkOutput("defer_entry", dut_pack(0), exp_out(0, 14, 0, 0, 0));
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 0, 4'd0, 0, 0, 1);
            step();
            checkOutput("defer_hold", dut_pack(0), exp_out(0, 14, 0, 0, 0));
        end
        applyStimulus(1, 0, 4'd0, 0, 0, 0);
        step();
        checkOutput("defer_release", dut_pack(0), exp_out(1, 14, 0, 0, 0));
        applyStimulus(1, 0, 4'd0, 1, 1, 0);
        step();
        checkOutput("defer_fall", dut_pack(0), exp_out(0, 0, 0, 0, 0));
        applyStimulus(1, 0, 4'd0, 0, 0, 0);
        step();
        checkOutput("defer_done", dut_pack(0), exp_out(0, 0, 1, 0, 1));

        // Three exchanges followed by a partner retry on the N_HS=3 instance.
        applyStimulus(0, 0, 4'd0, 0, 0, 0);
        step();
        applyStimulus(1, 0, 4'd0, 0, 0, 0);
        step();
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1, 1, 4'd15, 0, 0, 0);
            step();
            checkOutput($sformatf("nhs_send%0d", i), dut_pack(1), exp_out(1, 14, i > 3, 0, (i > 3) ? 3 : i - 1));
            applyStimulus(1, 0, 4'd0, 1, 0, 0);
            step();
            applyStimulus(1, 0, 4'd0, 0, 1, 0);
            step();
            applyStimulus(1, 0, 4'd0, 0, 0, 0);
            step();
            checkOutput($sformatf("nhs_count%0d", i), dut_pack(1), exp_out(0, 0, i >= 3, 0, (i > 3) ? 3 : i));
        end

        // No request at all: the 50-cycle instance times out at cycle 51.
        applyStimulus(0, 0, 4'd0, 0, 0, 0);
        step();
        applyStimulus(1, 0, 4'd0, 0, 0, 0);
        step();
        repeat (49) step();
        checkOutput("to_cycle50", dut_pack(2), exp_out(0, 0, 0, 0, 0));
        step();
        checkOutput("to_cycle51", dut_pack(2), exp_out(0, 0, 0, 1, 0));
        step();
        step();
        checkOutput("to_sticky", dut_pack(2), exp_out(0, 0, 0, 1, 0));
        applyStimulus(0, 0, 4'd0, 0, 0, 0);
        step();
        checkOutput("to_release", dut_pack(2), exp_out(0, 0, 0, 0, 0));

        // Wrong code, missing strobe, then an abort while the response is out.
        applyStimulus(1, 0, 4'd0, 0, 0, 0);
        step();
        applyStimulus(1, 1, 4'd13, 0, 0, 0);
        step();
        checkOutput("noise_code13", dut_pack(0), exp_out(0, 0, 0, 0, 0));
        applyStimulus(1, 0, 4'd15, 0, 0, 0);
        step();
        checkOutput("noise_nostrobe", dut_pack(0), exp_out(0, 0, 0, 0, 0));
        applyStimulus(1, 1, 4'd15, 0, 0, 0);
        step();
        checkOutput("abort_send", dut_pack(0), exp_out(1, 14, 0, 0, 0));
        applyStimulus(0, 0, 4'd0, 1, 0, 0);
        step();
        checkOutput("abort_drop", dut_pack(0), exp_out(0, 0, 0, 0, 0));
        applyStimulus(1, 0, 4'd0, 0, 0, 0);
        step();
        checkOutput("abort_rearm", dut_pack(0), exp_out(0, 0, 0, 0, 0));
        applyStimulus(1, 1, 4'd15, 0, 0, 0);
        step();
        checkOutput("abort_resend", dut_pack(0), exp_out(1, 14, 0, 0, 0));

        // Synchronous reset while the response is on the bus.
        rst = 1'b1;
        applyStimulus(1, 0, 4'd0, 1, 0, 0);
        step();
        for (int k = 0; k < NDUT; k++) checkOutput($sformatf("midreset_dut%0d", k), dut_pack(k), exp_out(0, 0, 0, 0, 0));
        rst = 1'b0;
        applyStimulus(1, 0, 4'd0, 0, 0, 0);
        step();
        applyStimulus(1, 1, 4'd15, 0, 0, 0);
        step();
        checkOutput("postreset_send", dut_pack(0), exp_out(1, 14, 0, 0, 0));

        for (int c = 0; c < 3000; c++) begin
            rst  = ($urandom_range(0, 299) == 0);
            rmsg = ($urandom_range(0, 3) < 2) ? 4'd15 : 4'($urandom_range(0, 15));
            applyStimulus($urandom_range(0, 79) != 0, $urandom_range(0, 4) == 0, rmsg,
                          $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
            step();
        end

        check_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ltsm_rx_hs_responder.md
Name: ltsm_rx_hs_responder

Overview:
Parametrised RX-side sideband handshake responder for LTSM substates (TRAINERROR, and any other substate using a single request/response exchange).
- Waits for a configured request code from the partner and answers with a configured response code.
- Yields the sideband bus to the local TX handshake when TX holds it.
- Supports N repeated exchanges, re-answers partner retries after completion, and flags a timeout.
- Sits between the LTSM substate controller, the SB decoder/encoder and the SB wrapper valid/busy handshake.

Parameters:
SB_MSG_WIDTH, 4, width of decoded/encoded SB message codes
REQ_MSG, 15, request code to answer (TRAINERROR entry req)
RESP_MSG, 14, response code to send (TRAINERROR entry resp)
N_HS, 1, exchanges required before o_done (1..2^CNT_W-1)
CNT_W, 4, width of o_hs_count
TIMEOUT_CYCLES, 800000, cycles without progress before timeout (8 ms at 100 MHz); 0 disables
TO_W, 20, timeout counter width (must hold TIMEOUT_CYCLES)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_en  in  1  substate enable from LTSM; low returns block to IDLE
i_sb_msg_valid  in  1  one-cycle strobe: i_decoded_SB_msg holds a new message
i_decoded_SB_msg  in  SB_MSG_WIDTH  decoded partner message
i_sb_busy  in  1  SB transmitter busy
i_sb_busy_fall  in  1  one-cycle pulse: SB finished sending current message
i_tx_valid  in  1  local TX handshake currently owns the bus
o_encoded_SB_msg  out  SB_MSG_WIDTH  message code to encode (RESP_MSG or 0)
o_valid  out  1  request SB to send o_encoded_SB_msg
o_done  out  1  N_HS exchanges completed (level)
o_timeout  out  1  sticky timeout flag
o_hs_count  out  CNT_W  completed exchanges

Behaviour:
- Reset (i_rst high at a clock edge): state IDLE, all outputs 0, counters 0.
- All outputs are registered.
- "Accept" = i_sb_msg_valid && i_decoded_SB_msg==REQ_MSG. Other codes and strobe-less values are ignored.
- States:
  - IDLE: i_en -> WAIT_REQ.
  - WAIT_REQ: accept at cycle T ->
    - if !i_sb_busy && !i_tx_valid at T: SEND_RESP at T+1, with o_valid=1 and o_encoded_SB_msg=RESP_MSG at T+1;
    - else DEFER at T+1, with o_encoded_SB_msg=RESP_MSG.
  - DEFER: first cycle with !i_sb_busy && !i_tx_valid -> SEND_RESP next cycle, o_valid=1.
  - SEND_RESP:
    - i_sb_busy_fall clears o_valid next cycle.
    - The cycle after o_valid falls, o_hs_count increments.
    - Then -> DONE if the new count==N_HS, else WAIT_REQ.
    - Accepts arriving during SEND_RESP/DEFER are dropped.
  - DONE: o_done=1.
    - Accept -> retry path (DEFER/SEND_RESP rules as above) without incrementing o_hs_count; returns to DONE; o_done stays 1.
  - TIMEOUT: o_timeout=1, o_valid=0. Only exit is !i_en.
- i_en low in any state: IDLE next cycle; o_valid, o_done, o_timeout, o_hs_count, o_encoded_SB_msg cleared that same next-cycle edge. An in-flight o_valid is abandoned.
- i_sb_busy_fall while o_valid=0: ignored.
- i_sb_busy_fall and a new accept in the same cycle: the busy fall is processed and the accept is dropped.
- Timeout counter:
  - Counts in WAIT_REQ, DEFER and SEND_RESP; clears on accept, on entry to DONE, and in IDLE; frozen in DONE/TIMEOUT.
  - Reaching TIMEOUT_CYCLES-1 -> TIMEOUT next cycle.
  - If an accept and the terminal count occur in the same cycle, the accept wins.
  - Counter saturates and never wraps.
- o_hs_count saturates at N_HS.

Decomposition:
- Shared package ltsm_sb_pkg holds the SB message code constants (REQ/RESP codes per substate) and the state encoding typedef for handshake responders.
- One sub-module, ltsm_hs_timeout_cnt: parametrised saturating counter with clear, enable and terminal-count flag, reusable by the TX-side handshake blocks.

Test Plan:
- N_HS=1, bus idle: i_en=1; accept at T -> o_valid=1, o_encoded_SB_msg=14 at T+1. i_sb_busy_fall at T+5 -> o_valid=0 at T+6; o_hs_count=1 and o_done=1 by T+8.
- TX contention: i_tx_valid=1 through T+10 while accept arrives at T -> state DEFER and o_valid=0 until i_tx_valid drops; o_valid=1 at T+12; completes normally.
- N_HS=3 with a partner retry: three accept/busy-fall cycles -> o_hs_count 1,2,3; o_done after the third. A fourth accept -> o_valid pulses again, o_hs_count stays 3, o_done stays 1.
- Timeout: TIMEOUT_CYCLES=50, no request after i_en -> o_timeout=1 at cycle 51 and stays high. Drop i_en -> all outputs 0 the next cycle.
- Noise/abort: code 13 with strobe and code 15 without strobe -> no response. Valid accept, then i_en=0 while o_valid=1 -> o_valid=0 the next cycle, state IDLE.
- Reset mid-SEND_RESP: i_rst=1 for one edge -> all outputs 0 that edge. Releasing i_rst with i_en=1 -> WAIT_REQ.
